// File: rtl/seq_stage_ctrl_if.sv
// Control/status bundle between the sequencer and
// the fetch, memory and PC-update stages.
interface seq_stage_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             start;
  logic [3:0]       icode;
  logic             instr_valid;
  logic             imem_error;
  logic             mem_ack;
  logic             dmem_error;
  logic             fetch_en;
  logic             decode_en;
  logic             execute_en;
  logic             memory_en;
  logic             wb_en;
  logic             mem_req;
  logic             pc_we;
  logic [1:0]       status;
  logic             busy;
  logic [CNT_W-1:0] retired;

  modport master (
    output start, icode, instr_valid,
    output imem_error, mem_ack, dmem_error,
    input  fetch_en, decode_en, execute_en,
    input  memory_en, wb_en, mem_req,
    input  pc_we, status, busy, retired
  );

  modport slave (
    input  start, icode, instr_valid,
    input  imem_error, mem_ack, dmem_error,
    output fetch_en, decode_en, execute_en,
    output memory_en, wb_en, mem_req,
    output pc_we, status, busy, retired
  );
endinterface

// File: rtl/seq_stage_ctrl.sv
// Multi-cycle instruction sequencer: walks each
// instruction through the stages, tracks faults.
module seq_stage_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input logic             clk,
  input logic             rst_n,
  seq_stage_ctrl_if.slave bus
);

  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0] TMO = WW'(MEM_TIMEOUT);

  localparam logic [1:0] ST_AOK = 2'd0;
  localparam logic [1:0] ST_HLT = 2'd1;
  localparam logic [1:0] ST_ADR = 2'd2;
  localparam logic [1:0] ST_INS = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WB,
    S_PCUPD,
    S_HALTED
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       status_q, status_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic fetch_en_q, fetch_en_d;
  logic decode_en_q, decode_en_d;
  logic execute_en_q, execute_en_d;
  logic memory_en_q, memory_en_d;
  logic wb_en_q, wb_en_d;
  logic mem_req_q, mem_req_d;
  logic pc_we_q, pc_we_d;
  logic busy_q, busy_d;

  logic is_mem;

  assign is_mem = bus.icode inside {
    4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB
  };

  always_comb begin
    state_d   = state_q;
    status_d  = status_q;
    wait_d    = wait_q;
    retired_d = retired_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (bus.imem_error) begin
          state_d  = S_HALTED;
          status_d = ST_ADR;
        end else if (!bus.instr_valid) begin
          state_d  = S_HALTED;
          status_d = ST_INS;
        end else if (bus.icode == 4'h0) begin
          state_d  = S_HALTED;
          status_d = ST_HLT;
        end else begin
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXECUTE;
      S_EXECUTE: begin
        state_d = S_MEMORY;
        wait_d  = '0;
      end
      S_MEMORY: begin
        // ack beats timeout when both land together
        if (!is_mem) begin
          state_d = S_WB;
        end else if (bus.mem_ack) begin
          if (bus.dmem_error) begin
            state_d  = S_HALTED;
            status_d = ST_ADR;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_q == TMO) begin
          state_d  = S_HALTED;
          status_d = ST_ADR;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_WB: state_d = S_PCUPD;
      S_PCUPD: begin
        state_d   = S_FETCH;
        retired_d = retired_q + 1'b1;
      end
      S_HALTED: state_d = S_HALTED;
    endcase
  end

  always_comb begin
    fetch_en_d   = (state_d == S_FETCH);
    decode_en_d  = (state_d == S_DECODE);
    execute_en_d = (state_d == S_EXECUTE);
    memory_en_d  = (state_d == S_MEMORY);
    wb_en_d      = (state_d == S_WB);
    mem_req_d    = (state_d == S_MEMORY) && is_mem;
    pc_we_d      = (state_d == S_PCUPD);
    busy_d       = (state_d != S_IDLE) &&
                   (state_d != S_HALTED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      status_q     <= ST_AOK;
      wait_q       <= '0;
      retired_q    <= '0;
      fetch_en_q   <= 1'b0;
      decode_en_q  <= 1'b0;
      execute_en_q <= 1'b0;
      memory_en_q  <= 1'b0;
      wb_en_q      <= 1'b0;
      mem_req_q    <= 1'b0;
      pc_we_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      status_q     <= status_d;
      wait_q       <= wait_d;
      retired_q    <= retired_d;
      fetch_en_q   <= fetch_en_d;
      decode_en_q  <= decode_en_d;
      execute_en_q <= execute_en_d;
      memory_en_q  <= memory_en_d;
      wb_en_q      <= wb_en_d;
      mem_req_q    <= mem_req_d;
      pc_we_q      <= pc_we_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.fetch_en   = fetch_en_q;
  assign bus.decode_en  = decode_en_q;
  assign bus.execute_en = execute_en_q;
  assign bus.memory_en  = memory_en_q;
  assign bus.wb_en      = wb_en_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.pc_we      = pc_we_q;
  assign bus.status     = status_q;
  assign bus.busy       = busy_q;
  assign bus.retired    = retired_q;

endmodule

// File: doc/seq_stage_ctrl.md
SEQ_STAGE_CTRL -- requirements
Module: seq_stage_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15: max cycles MEMORY waits for mem_ack before a fault.
REQ-002 Parameter CNT_W, default 32: width of retired-instruction counter.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  begin execution; sampled only in IDLE.
REQ-006 icode  input  4  instruction code from fetch logic; valid from FETCH through PCUPD.
REQ-007 instr_valid  input  1  fetch decoded a legal icode/ifun.
REQ-008 imem_error  input  1  fetch address out of range.
REQ-009 mem_ack  input  1  data memory completed the request.
REQ-010 dmem_error  input  1  data memory address fault; qualified by mem_ack.
REQ-011 fetch_en, decode_en, execute_en, memory_en, wb_en  output  1 each  stage enables, one-hot with state.
REQ-012 mem_req  output  1  data memory request, held while waiting.
REQ-013 pc_we  output  1  one-cycle PC update strobe to PC-update stage.
REQ-014 status  output  2  0=AOK, 1=HLT, 2=ADR, 3=INS.
REQ-015 busy  output  1  high in any state except IDLE and HALTED.
REQ-016 retired  output  CNT_W  count of instructions that completed PC update.

Function
REQ-017 FSM states: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALTED; each stage enable is high exactly in its state, all low otherwise.
REQ-018 IDLE -> FETCH on start=1; start ignored in every other state.
REQ-019 FETCH lasts one cycle; priority at exit: imem_error -> status ADR, HALTED; else instr_valid=0 -> status INS, HALTED; else icode=0 -> status HLT, HALTED; else DECODE.
REQ-020 DECODE and EXECUTE last one cycle each, unconditionally advancing.
REQ-021 MEMORY: icode in {4,5,8,9,A,B} asserts mem_req from MEMORY entry until the cycle mem_ack=1 inclusive; all other icodes spend one cycle in MEMORY with mem_req=0.
REQ-022 On mem_ack=1 with dmem_error=1 -> status ADR, HALTED, no writeback, no pc_we.
REQ-023 On mem_ack=1 with dmem_error=0 -> WRITEBACK.
REQ-024 Wait counter starts at 0 on MEMORY entry, increments each cycle without mem_ack; reaching MEM_TIMEOUT with mem_ack=0 -> status ADR, HALTED, mem_req drops.
REQ-025 mem_ack and timeout in the same cycle: mem_ack wins.
REQ-026 mem_ack outside a memory-access MEMORY state is ignored.
REQ-027 WRITEBACK lasts one cycle -> PCUPD.
REQ-028 PCUPD lasts one cycle, asserts pc_we=1, increments retired (wraps modulo 2^CNT_W), then -> FETCH.
REQ-029 Run is continuous: one instruction every 6 cycles plus memory wait cycles, until a fault or halt.
REQ-030 HALTED is terminal; only rst_n leaves it; status holds its fault value, pc_we never asserts there.
REQ-031 status changes only on entry to HALTED; remains AOK otherwise.
REQ-032 pc_we never asserts for an instruction that faulted or halted, so PC stays at the faulting instruction.

Reset
REQ-033 rst_n=0 asynchronously forces IDLE, status=0, retired=0, wait counter=0, all enables, mem_req, pc_we, busy = 0.
REQ-034 Reset asserted mid-instruction (including during a pending mem_req) aborts with no pc_we pulse; mem_req drops immediately.
REQ-035 After rst_n rises, block stays in IDLE until start=1.

Verification
REQ-036 Reset, start, icode=6 (OPq), instr_valid=1 x3 -> fetch_en every 6 cycles, pc_we pulses 3 times, retired=3, status=0, mem_req never high.
REQ-037 icode=5, mem_ack after 4 wait cycles -> mem_req high 5 cycles, instruction takes 10 cycles, retired +1.
REQ-038 icode=A, mem_ack never -> after 15 wait cycles status=2, HALTED, busy=0, no pc_we; mem_ack arriving in cycle 15 instead -> normal completion.
REQ-039 icode=0 after 2 OPq -> status=1, retired=2, start afterwards has no effect; instr_valid=0 -> status=3; imem_error with instr_valid=0 -> status=2.
REQ-040 rst_n pulsed low during MEMORY wait -> outputs zero same cycle (async), no pc_we, IDLE after release; mem_ack with dmem_error=1 -> status=2, wb_en never asserted.
